mips_processor: RTL and testbench

Single-cycle 32-bit MIPS-subset processor, top of the `mips/processor/singlecycle` design. It contains an instruction fetch unit with a byte-addressed instruction memory, a 32×32 register file, ALU, control and data memory. Every instruction fetches, executes and commits in one clock. Instance hierarchy is fixed so benches can preload and inspect state: instruction bytes at `IFU.imemory.storage.bytes[]`, registers at `registers.registers[0:31]`.

---
 rtl/mips_processor.sv | 216 +++++++++++++++++++++
 tb/tb_mips_processor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_processor.sv
// Single-cycle MIPS-subset core: fetch, decode, execute and commit in one clock.
// Optional macro PROCESSOR_JUMP_EN enables j/jal; without it, opcodes 0x02/0x03 act as nops.

module mips_bytemem #(
    parameter int BYTES = 1024
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o
);
    localparam int AW = $clog2(BYTES);

    logic [7:0]    bytes [0:BYTES-1];
    logic [AW-3:0] wword, rword;
    logic          unused_addr;

    // Word-aligned and wrapped: low two bits and bits above the array size are dropped.
    assign wword       = waddr_i[AW-1:2];
    assign rword       = raddr_i[AW-1:2];
    assign unused_addr = ^{waddr_i[31:AW], waddr_i[1:0], raddr_i[31:AW], raddr_i[1:0]};

    assign rdata_o = {bytes[{rword, 2'b00}], bytes[{rword, 2'b01}],
                      bytes[{rword, 2'b10}], bytes[{rword, 2'b11}]};

    always_ff @(posedge clk) begin
        if (we_i) begin
            bytes[{wword, 2'b00}] <= wdata_i[31:24];
            bytes[{wword, 2'b01}] <= wdata_i[23:16];
            bytes[{wword, 2'b10}] <= wdata_i[15:8];
            bytes[{wword, 2'b11}] <= wdata_i[7:0];
        end
    end
endmodule

module mips_imem #(
    parameter int BYTES = 1024
) (
    input  logic        clk,
    input  logic [31:0] addr_i,
    output logic [31:0] data_o
);
    // Read-only from the core's point of view; contents are preloaded externally.
    mips_bytemem #(.BYTES(BYTES)) storage (
        .clk     (clk),
        .we_i    (1'b0),
        .waddr_i (32'd0),
        .wdata_i (32'd0),
        .raddr_i (addr_i),
        .rdata_o (data_o)
    );
endmodule

module mips_ifu #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o
);
    mips_imem #(.BYTES(IMEM_BYTES)) imemory (
        .clk    (clk),
        .addr_i (pc_i),
        .data_o (instr_o)
    );
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] registers [0:31];

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : registers[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : registers[ra2_i];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            registers[wa_i] <= wd_i;
        end
    end
endmodule

module mips_processor #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc
);
    logic [31:0] pc_q, pc_d, pc_plus4, instr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] imm_s, imm_z, rs_v, rt_v, branch_tgt;
    logic [31:0] dmem_addr, dmem_rdata;
    logic        rf_we, mem_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    mips_ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
        .clk     (clk),
        .pc_i    (pc_q),
        .instr_o (instr)
    );

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
    assign imm_s = {{16{imm[15]}}, imm};
    assign imm_z = {16'd0, imm};
    assign branch_tgt = pc_plus4 + {imm_s[29:0], 2'b00};

`ifdef PROCESSOR_JUMP_EN
    logic [31:0] jump_tgt;
    assign jump_tgt = {pc_plus4[31:28], instr[25:0], 2'b00};
`endif

    mips_regfile registers (
        .clk     (clk),
        .reset_i (reset),
        .ra1_i   (rs),
        .ra2_i   (rt),
        .rd1_o   (rs_v),
        .rd2_o   (rt_v),
        .we_i    (rf_we),
        .wa_i    (rf_wa),
        .wd_i    (rf_wd)
    );

    assign dmem_addr = rs_v + imm_s;

    // A store in flight when reset is asserted must not commit.
    mips_bytemem #(.BYTES(DMEM_BYTES)) dmemory (
        .clk     (clk),
        .we_i    (mem_we && !reset),
        .waddr_i (dmem_addr),
        .wdata_i (rt_v),
        .raddr_i (dmem_addr),
        .rdata_o (dmem_rdata)
    );

    always_comb begin
        rf_we  = 1'b0;
        rf_wa  = rt;
        rf_wd  = 32'd0;
        mem_we = 1'b0;
        pc_d   = pc_plus4;
        case (op)
            6'h00: begin
                rf_we = 1'b1;
                rf_wa = rd;
                case (funct)
                    6'h00: rf_wd = rt_v << shamt;
                    6'h02: rf_wd = rt_v >> shamt;
                    6'h03: rf_wd = $signed(rt_v) >>> shamt;
                    6'h08: begin rf_we = 1'b0; pc_d = rs_v; end
                    6'h20, 6'h21: rf_wd = rs_v + rt_v;
                    6'h22, 6'h23: rf_wd = rs_v - rt_v;
                    6'h24: rf_wd = rs_v & rt_v;
                    6'h25: rf_wd = rs_v | rt_v;
                    6'h26: rf_wd = rs_v ^ rt_v;
                    6'h27: rf_wd = ~(rs_v | rt_v);
                    6'h2A: rf_wd = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    6'h2B: rf_wd = {31'd0, rs_v < rt_v};
                    default: rf_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin rf_we = 1'b1; rf_wd = rs_v + imm_s; end
            6'h0A: begin rf_we = 1'b1; rf_wd = {31'd0, $signed(rs_v) < $signed(imm_s)}; end
            6'h0B: begin rf_we = 1'b1; rf_wd = {31'd0, rs_v < imm_s}; end
            6'h0C: begin rf_we = 1'b1; rf_wd = rs_v & imm_z; end
            6'h0D: begin rf_we = 1'b1; rf_wd = rs_v | imm_z; end
            6'h0E: begin rf_we = 1'b1; rf_wd = rs_v ^ imm_z; end
            6'h0F: begin rf_we = 1'b1; rf_wd = {imm, 16'd0}; end
            6'h23: begin rf_we = 1'b1; rf_wd = dmem_rdata; end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_v == rt_v) pc_d = branch_tgt;
            6'h05: if (rs_v != rt_v) pc_d = branch_tgt;
`ifdef PROCESSOR_JUMP_EN
            6'h02: pc_d = jump_tgt;
            6'h03: begin
                pc_d  = jump_tgt;
                rf_we = 1'b1;
                rf_wa = 5'd31;
                rf_wd = pc_plus4;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= 32'd0;
        else       pc_q <= pc_d;
    end
endmodule

// File: tb/tb_mips_processor.sv
// Directed bench for mips_processor: programs are poked into instruction memory, then state is inspected.
module tb_mips_processor;
    logic        clk;
    logic        reset;
    logic [31:0] pc;
    int          checks;
    int          failures;

    mips_processor #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) dut.IFU.imemory.storage.bytes[i] = 8'h00;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.IFU.imemory.storage.bytes[addr]   = w[31:24];
        dut.IFU.imemory.storage.bytes[addr+1] = w[23:16];
        dut.IFU.imemory.storage.bytes[addr+2] = w[15:8];
        dut.IFU.imemory.storage.bytes[addr+3] = w[7:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic load_addi_prog();
        clear_imem();
        put(0,  enc_i(6'h08, 5'd0, 5'd16, 16'd0));
        put(4,  enc_i(6'h08, 5'd0, 5'd17, 16'd3));
        put(8,  enc_i(6'h08, 5'd0, 5'd8,  16'd255));
        put(12, enc_i(6'h08, 5'd0, 5'd9,  16'hFFFD));
    endtask

    task automatic test_reset();
        load_addi_prog();
        do_reset();
        chk("reset_pc", pc, 32'd0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("reset_r%0d", i), dut.registers.registers[i], 32'd0);
    endtask

    task automatic test_addi();
        load_addi_prog();
        do_reset();
        step(4);
        chk("addi_s0", dut.registers.registers[16], 32'd0);
        chk("addi_s1", dut.registers.registers[17], 32'd3);
        chk("addi_t0", dut.registers.registers[8], 32'd255);
        chk("addi_t1", dut.registers.registers[9], 32'hFFFFFFFD);
        chk("addi_pc", pc, 32'd16);
    endtask

    task automatic test_reset_mid();
        load_addi_prog();
        do_reset();
        step(2);
        chk("mid_pre_s1", dut.registers.registers[17], 32'd3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_pc", pc, 32'd0);
        chk("mid_t0_not_committed", dut.registers.registers[8], 32'd0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("mid_r%0d", i), dut.registers.registers[i], 32'd0);
    endtask

    task automatic test_wrap();
        clear_imem();
        put(0,  enc_i(6'h0F, 5'd0, 5'd8, 16'h7FFF));
        put(4,  enc_i(6'h0D, 5'd8, 5'd8, 16'hFFFF));
        put(8,  enc_i(6'h08, 5'd8, 5'd8, 16'd1));
        put(12, enc_i(6'h08, 5'd0, 5'd0, 16'd5));
        do_reset();
        step(2);
        chk("wrap_lui_ori", dut.registers.registers[8], 32'h7FFFFFFF);
        step(2);
        chk("wrap_t0", dut.registers.registers[8], 32'h80000000);
        chk("wrap_r0", dut.registers.registers[0], 32'd0);
        chk("wrap_pc", pc, 32'd16);
    endtask

    task automatic test_alu();
        clear_imem();
        put(0,  enc_i(6'h08, 5'd0, 5'd8, 16'hFFF8));
        put(4,  enc_r(5'd0, 5'd8, 5'd9,  5'd1,  6'h03));
        put(8,  enc_r(5'd0, 5'd8, 5'd10, 5'd28, 6'h02));
        put(12, enc_r(5'd0, 5'd8, 5'd11, 5'd4,  6'h00));
        put(16, enc_r(5'd10, 5'd8, 5'd12, 5'd0, 6'h22));
        put(20, enc_r(5'd8, 5'd0, 5'd13, 5'd0,  6'h27));
        put(24, enc_i(6'h0E, 5'd10, 5'd14, 16'h00FF));
        do_reset();
        step(7);
        chk("alu_sra", dut.registers.registers[9],  32'hFFFFFFFC);
        chk("alu_srl", dut.registers.registers[10], 32'h0000000F);
        chk("alu_sll", dut.registers.registers[11], 32'hFFFFFF80);
        chk("alu_sub", dut.registers.registers[12], 32'd23);
        chk("alu_nor", dut.registers.registers[13], 32'd7);
        chk("alu_xori", dut.registers.registers[14], 32'h000000F0);
    endtask

    task automatic test_mem();
        clear_imem();
        put(0, enc_i(6'h08, 5'd0, 5'd8, 16'h1234));
        put(4, enc_i(6'h2B, 5'd0, 5'd8, 16'd8));
        put(8, enc_i(6'h23, 5'd0, 5'd9, 16'd8));
        do_reset();
        step(3);
        chk("mem_lw_t1", dut.registers.registers[9], 32'h00001234);
        chk("mem_b8",  {24'd0, dut.dmemory.bytes[8]},  32'h00);
        chk("mem_b9",  {24'd0, dut.dmemory.bytes[9]},  32'h00);
        chk("mem_b10", {24'd0, dut.dmemory.bytes[10]}, 32'h12);
        chk("mem_b11", {24'd0, dut.dmemory.bytes[11]}, 32'h34);
    endtask

    task automatic test_branch();
        clear_imem();
        put(0,  enc_i(6'h08, 5'd0, 5'd8, 16'd5));
        put(4,  enc_i(6'h08, 5'd0, 5'd9, 16'd5));
        put(8,  enc_i(6'h04, 5'd8, 5'd9, 16'd2));
        put(12, enc_i(6'h08, 5'd0, 5'd16, 16'd1));
        put(16, enc_i(6'h08, 5'd0, 5'd16, 16'd2));
        put(20, enc_i(6'h05, 5'd8, 5'd9, 16'd5));
        put(24, enc_i(6'h08, 5'd0, 5'd17, 16'hFFFF));
        put(28, enc_i(6'h08, 5'd0, 5'd10, 16'd1));
        put(32, enc_r(5'd17, 5'd10, 5'd11, 5'd0, 6'h2A));
        put(36, enc_r(5'd17, 5'd10, 5'd12, 5'd0, 6'h2B));
        do_reset();
        step(3);
        chk("beq_taken_pc", pc, 32'd20);
        step(1);
        chk("bne_not_taken_pc", pc, 32'd24);
        step(4);
        chk("branch_end_pc", pc, 32'd40);
        chk("branch_skipped_s0", dut.registers.registers[16], 32'd0);
        chk("slt_neg1_1", dut.registers.registers[11], 32'd1);
        chk("sltu_neg1_1", dut.registers.registers[12], 32'd0);
    endtask

    task automatic test_jump();
        clear_imem();
        put(0,    enc_i(6'h08, 5'd0, 5'd8, 16'd1));
        put(4,    {6'h03, 26'h10});
        put(8,    enc_i(6'h08, 5'd0, 5'd9, 16'h0080));
        put(12,   enc_r(5'd9, 5'd0, 5'd0, 5'd0, 6'h08));
        put(64,   enc_i(6'h08, 5'd0, 5'd9, 16'h0080));
        put(68,   enc_r(5'd9, 5'd0, 5'd0, 5'd0, 6'h08));
        do_reset();
        step(2);
`ifdef PROCESSOR_JUMP_EN
        chk("jal_pc", pc, 32'h40);
        chk("jal_ra", dut.registers.registers[31], 32'd8);
`else
        chk("jal_nop_pc", pc, 32'd8);
        chk("jal_nop_ra", dut.registers.registers[31], 32'd0);
`endif
        step(2);
        chk("jr_pc", pc, 32'h80);
        chk("jr_t1", dut.registers.registers[9], 32'h80);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        @(negedge clk);
        test_reset();
        test_addi();
        test_reset_mid();
        test_wrap();
        test_alu();
        test_mem();
        test_branch();
        test_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
